// File: rtl/out_stream_pkg.sv
// out_stream_pkg: shared state encoding and frame-size helpers for the output streamer
package out_stream_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int DEF_AW = 12;
  function automatic logic [31:0] clamp_limit(input int aw);
    return 32'(1) << aw;
  endfunction
  function automatic logic [31:0] frame_total(input logic [15:0] w, input logic [15:0] h, input int aw);
    logic [31:0] p;
    p = 32'(w) * 32'(h);
    return p > clamp_limit(aw) ? clamp_limit(aw) : p;
  endfunction
endpackage

// File: rtl/sync_fifo_small.sv
// sync_fifo_small: tiny byte FIFO with occupancy count and same-cycle push/pop
module sync_fifo_small #(
  parameter int D = 2
) (
  input  logic                 clk_50,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [7:0]           din,
  input  logic                 pop,
  output logic [7:0]           dout,
  output logic [$clog2(D):0]   count
);
  localparam int PW = $clog2(D);
  logic [7:0] mem [D];
  logic [PW-1:0] rp, wp;
  assign dout = mem[rp];
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/out_frame_streamer.sv
// out_frame_streamer: raster-walks the output BRAM and streams pixels with checksum and perf counters
module out_frame_streamer
  import out_stream_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int FIFO_D = 2
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   i_out_w,
  input  logic [15:0]   i_out_h,
  output logic [AW-1:0] mem_raddr,
  input  logic [7:0]    mem_rdata,
  output logic          o_valid,
  output logic [7:0]    o_data,
  output logic          o_last,
  input  logic          i_ready,
  output logic          busy,
  output logic          done,
  output logic [31:0]   o_checksum,
  output logic [31:0]   o_pix_count,
  output logic [31:0]   o_stall_cycles
);
  typedef logic [AW:0] cnt_t;
  state_t state;
  cnt_t total, issued;
  logic inflight, hs, rd_en;
  logic [$clog2(FIFO_D):0] fifo_count;
  assign o_valid = fifo_count != '0;
  assign hs = o_valid && i_ready;
  // a pop this cycle frees a slot, so reservation stays full-rate with a ready sink
  assign rd_en = state == S_RUN && issued != total &&
                 32'(fifo_count) + 32'(inflight) - 32'(hs) < 32'(FIFO_D);
  assign mem_raddr = issued[AW-1:0];
  assign o_last = o_valid && o_pix_count == 32'(total) - 32'd1;
  sync_fifo_small #(.D(FIFO_D)) u_fifo (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .push   (inflight),
    .din    (mem_rdata),
    .pop    (hs),
    .dout   (o_data),
    .count  (fifo_count)
  );
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      total <= '0;
      issued <= '0;
      inflight <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      o_checksum <= '0;
      o_pix_count <= '0;
      o_stall_cycles <= '0;
    end else begin
      inflight <= rd_en;
      done <= 1'b0;
      if (hs) begin
        o_checksum <= o_checksum + 32'(o_data);
        o_pix_count <= o_pix_count + 32'd1;
      end
      if (o_valid && !i_ready) o_stall_cycles <= o_stall_cycles + 32'd1;
      case (state)
        S_IDLE: if (start) begin
          total <= cnt_t'(frame_total(i_out_w, i_out_h, AW));
          issued <= '0;
          o_checksum <= '0;
          o_pix_count <= '0;
          o_stall_cycles <= '0;
          busy <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: begin
          if (rd_en) issued <= issued + cnt_t'(1);
          if (issued == total) state <= S_DRAIN;
        end
        S_DRAIN: if (o_pix_count + 32'(hs) == 32'(total)) begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_out_frame_streamer.sv
// tb_out_frame_streamer: randomized scenario bench against a BRAM model and an expected-pixel model
module tb_out_frame_streamer;
  localparam int AW = 12;
  localparam int CAP = 1 << AW;
  logic clk_50 = 1'b0, rst_n = 1'b0, start = 1'b0, i_ready = 1'b1;
  logic [15:0] i_out_w = '0, i_out_h = '0;
  logic [AW-1:0] mem_raddr;
  logic [7:0] mem_rdata = '0, o_data;
  logic o_valid, o_last, busy, done;
  logic [31:0] o_checksum, o_pix_count, o_stall_cycles;
  logic [7:0] mem [CAP];
  int vectors = 0, miscompares = 0;
  logic [7:0] got_q[$];
  bit last_q[$];
  int done_cnt, done_cyc, first_valid_cyc, last_hs_cyc, stalls_seen, unstable;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) mem_rdata <= mem[mem_raddr];

  out_frame_streamer #(.AW(AW), .FIFO_D(2)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .start(start), .i_out_w(i_out_w), .i_out_h(i_out_h),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .o_valid(o_valid), .o_data(o_data),
    .o_last(o_last), .i_ready(i_ready), .busy(busy), .done(done), .o_checksum(o_checksum),
    .o_pix_count(o_pix_count), .o_stall_cycles(o_stall_cycles)
  );

  function automatic int exp_total(input int w, input int h);
    return w * h > CAP ? CAP : w * h;
  endfunction
  function automatic logic [31:0] exp_sum(input int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i++) s += 32'(mem[i]);
    return s;
  endfunction
  function automatic int first_bad(input int n);
    for (int i = 0; i < got_q.size() && i < n; i++) if (got_q[i] !== mem[i]) return i;
    return -1;
  endfunction
  function automatic bit last_ok();
    int n = 0;
    foreach (last_q[i]) n += int'(last_q[i]);
    return last_q.size() > 0 && n == 1 && last_q[last_q.size()-1];
  endfunction
  task automatic fill_random();
    for (int i = 0; i < CAP; i++) mem[i] = 8'($urandom);
  endtask

  // ready_mode: 0 always ready, 1 alternate starting at the first valid cycle, 2 random
  task automatic stream(input int w, input int h, input int ready_mode, input int restart_at,
                        input int abort_at, input int budget);
    logic pv, ph;
    logic [7:0] pd;
    int c;
    got_q.delete(); last_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; stalls_seen = 0; unstable = 0;
    @(negedge clk_50);
    start = 1'b1; i_out_w = 16'(w); i_out_h = 16'(h);
    @(posedge clk_50);
    c = 0; pv = 0; ph = 0; pd = 0;
    #1 i_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      @(negedge clk_50);
      start = (c + 1 == restart_at);
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (pv && !ph && (!o_valid || o_data !== pd)) unstable++;
      if (o_valid && i_ready) begin got_q.push_back(o_data); last_q.push_back(o_last); last_hs_cyc = c; end
      if (o_valid && !i_ready) stalls_seen++;
      pv = o_valid; pd = o_data; ph = o_valid && i_ready;
      if (abort_at > 0 && got_q.size() == abort_at) begin rst_n = 1'b0; break; end
      if ((done_cyc >= 0 && c >= done_cyc + 3) || c >= budget) break;
      @(posedge clk_50);
      c++;
      #1 i_ready = ready_mode == 1 ? 1'(c % 2 == 0) : ready_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    if (abort_at == 0 && done_cyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout: no done within %0d cycles (got %0d beats)", budget, got_q.size());
    end
    if (abort_at == 0) i_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    vectors++; if ({o_valid, o_last, busy, done} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", {o_valid, o_last, busy, done}); end
    vectors++; if ({mem_raddr, o_data} !== '0) begin miscompares++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_raddr, o_data); end
    vectors++; if ({o_checksum, o_pix_count, o_stall_cycles} !== 96'd0) begin miscompares++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0", o_checksum, o_pix_count, o_stall_cycles); end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < CAP; i++) mem[i] = 8'(i);
    stream(4, 4, 0, -1, 0, 200);
    vectors++; if (got_q.size() !== 16) begin miscompares++; $display("FAIL ramp_beats: got %0d expected 16", got_q.size()); end
    vectors++; if (first_bad(16) !== -1) begin miscompares++; $display("FAIL ramp_data: bad beat %0d expected data 0..15", first_bad(16)); end
    vectors++; if (last_ok() !== 1'b1) begin miscompares++; $display("FAIL ramp_last: got misplaced o_last expected beat 16 only"); end
    vectors++; if (o_checksum !== 32'd120) begin miscompares++; $display("FAIL ramp_checksum: got %0d expected 120", o_checksum); end
    vectors++; if (o_stall_cycles !== 32'd0) begin miscompares++; $display("FAIL ramp_stalls: got %0d expected 0", o_stall_cycles); end
    vectors++; if (first_valid_cyc !== 2) begin miscompares++; $display("FAIL ramp_first_valid: got cycle %0d expected 2", first_valid_cyc); end
    vectors++; if (done_cyc !== 18) begin miscompares++; $display("FAIL ramp_done_time: got cycle %0d expected 18", done_cyc); end
    vectors++; if ({done_cnt, o_pix_count, busy} !== {32'd1, 32'd16, 1'b0}) begin miscompares++; $display("FAIL ramp_end: got done_cnt %0d pix %0d busy %b expected 1/16/0", done_cnt, o_pix_count, busy); end
  endtask

  task automatic test_toggle_ready();
    stream(4, 4, 1, -1, 0, 200);
    vectors++; if (got_q.size() !== 16 || first_bad(16) !== -1) begin miscompares++; $display("FAIL toggle_data: got %0d beats bad at %0d expected 16 clean", got_q.size(), first_bad(16)); end
    vectors++; if (o_stall_cycles !== 32'd15) begin miscompares++; $display("FAIL toggle_stalls: got %0d expected 15", o_stall_cycles); end
    vectors++; if (stalls_seen !== 15) begin miscompares++; $display("FAIL toggle_seen_stalls: got %0d expected 15", stalls_seen); end
    vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL toggle_hold: got %0d unstable stalls expected 0", unstable); end
    vectors++; if (o_checksum !== 32'd120) begin miscompares++; $display("FAIL toggle_checksum: got %0d expected 120", o_checksum); end
    vectors++; if (done_cyc !== last_hs_cyc + 1) begin miscompares++; $display("FAIL toggle_done_time: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
  endtask

  task automatic test_zero();
    fill_random();
    stream(0, 5, 0, -1, 0, 50);
    vectors++; if (first_valid_cyc !== -1) begin miscompares++; $display("FAIL zero_valid: got o_valid at cycle %0d expected none", first_valid_cyc); end
    vectors++; if (done_cyc !== 2) begin miscompares++; $display("FAIL zero_done_time: got cycle %0d expected 2", done_cyc); end
    vectors++; if ({done_cnt, o_pix_count} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL zero_counts: got done_cnt %0d pix %0d expected 1/0", done_cnt, o_pix_count); end
  endtask

  task automatic test_clamp();
    fill_random();
    stream(128, 64, 0, -1, 0, 5000);
    vectors++; if (got_q.size() !== CAP) begin miscompares++; $display("FAIL clamp_beats: got %0d expected %0d", got_q.size(), CAP); end
    vectors++; if (first_bad(CAP) !== -1) begin miscompares++; $display("FAIL clamp_data: bad beat %0d", first_bad(CAP)); end
    vectors++; if (last_ok() !== 1'b1) begin miscompares++; $display("FAIL clamp_last: got misplaced o_last expected address 4095 only"); end
    vectors++; if (o_pix_count !== 32'(CAP) || o_checksum !== exp_sum(CAP)) begin miscompares++; $display("FAIL clamp_counters: got %0d/%0d expected %0d/%0d", o_pix_count, o_checksum, CAP, exp_sum(CAP)); end
    vectors++; if (done_cyc !== CAP + 2) begin miscompares++; $display("FAIL clamp_done_time: got %0d expected %0d", done_cyc, CAP + 2); end
  endtask

  task automatic test_double_start();
    fill_random();
    stream(64, 64, 0, 5, 0, 5000);
    vectors++; if (got_q.size() !== CAP || first_bad(CAP) !== -1) begin miscompares++; $display("FAIL dstart_data: got %0d beats bad at %0d expected %0d clean", got_q.size(), first_bad(CAP), CAP); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL dstart_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (o_pix_count !== 32'(CAP)) begin miscompares++; $display("FAIL dstart_pix: got %0d expected %0d", o_pix_count, CAP); end
  endtask

  task automatic test_reset_mid();
    fill_random();
    stream(64, 64, 2, -1, 100, 5000);
    #1;
    vectors++; if ({o_valid, o_last, busy, done, mem_raddr, o_data} !== '0) begin miscompares++; $display("FAIL rmid_outputs: got v%b l%b b%b d%b a%h d%h expected all 0", o_valid, o_last, busy, done, mem_raddr, o_data); end
    vectors++; if ({o_checksum, o_pix_count, o_stall_cycles} !== 96'd0) begin miscompares++; $display("FAIL rmid_counters: got %0d/%0d/%0d expected 0", o_checksum, o_pix_count, o_stall_cycles); end
    vectors++; if (done_cnt !== 0 || first_bad(100) !== -1) begin miscompares++; $display("FAIL rmid_prefix: got done_cnt %0d bad at %0d expected 0/-1", done_cnt, first_bad(100)); end
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    i_ready = 1'b1;
    stream(16, 16, 0, -1, 0, 1000);
    vectors++; if (got_q.size() !== 256 || first_bad(256) !== -1) begin miscompares++; $display("FAIL rmid_restart: got %0d beats bad at %0d expected 256 from address 0", got_q.size(), first_bad(256)); end
    vectors++; if (done_cyc !== 258 || o_checksum !== exp_sum(256)) begin miscompares++; $display("FAIL rmid_restart_end: got done %0d sum %0d expected 258/%0d", done_cyc, o_checksum, exp_sum(256)); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int w, h, n;
      w = $urandom_range(1, 40); h = $urandom_range(1, 40); n = exp_total(w, h);
      fill_random();
      stream(w, h, 2, -1, 0, 10 * n + 50);
      vectors++; if (got_q.size() !== n || first_bad(n) !== -1) begin miscompares++; $display("FAIL rand_data %0dx%0d: got %0d beats bad at %0d expected %0d", w, h, got_q.size(), first_bad(n), n); end
      vectors++; if (o_checksum !== exp_sum(n) || o_pix_count !== 32'(n)) begin miscompares++; $display("FAIL rand_counters %0dx%0d: got %0d/%0d expected %0d/%0d", w, h, o_checksum, o_pix_count, exp_sum(n), n); end
      vectors++; if (o_stall_cycles !== 32'(stalls_seen) || unstable !== 0) begin miscompares++; $display("FAIL rand_stalls %0dx%0d: got %0d unstable %0d expected %0d/0", w, h, o_stall_cycles, unstable, stalls_seen); end
      vectors++; if (last_ok() !== 1'b1 || done_cyc !== last_hs_cyc + 1) begin miscompares++; $display("FAIL rand_end %0dx%0d: got last_ok %b done %0d expected 1/%0d", w, h, last_ok(), done_cyc, last_hs_cyc + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_toggle_ready();
    test_zero();
    test_clamp();
    test_double_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
